// File: rtl/parking_pkg.sv
// parking_pkg: result codes, allocator FSM states and floor-index width helper
package parking_pkg;
  localparam logic [2:0] RC_NONE = 3'd0, RC_GRANT_CHOSEN = 3'd1, RC_GRANT_ALT = 3'd2,
                         RC_NO_SPACE = 3'd3, RC_INVALID = 3'd4, RC_EXIT_OK = 3'd5, RC_EXIT_ERR = 3'd6;
  typedef enum logic [1:0] {IDLE, CHECK, SEARCH, HOLD} state_t;
  function automatic int flr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/parking_tick_gen.sv
// parking_tick_gen: TICK_DIV clock divider with a tick counter, both cleared by clr
module parking_tick_gen #(
  parameter int TICK_DIV = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] ticks
);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [DW-1:0] cyc;
  assign tick = cyc == DW'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cyc   <= '0;
      ticks <= '0;
    end else begin
      cyc   <= tick ? '0 : cyc + 1'b1;
      ticks <= ticks + CNT_W'(tick);
    end
  end
endmodule

// File: rtl/parking_floor_allocator.sv
// parking_floor_allocator: per-floor free counters with chosen/alternate floor allocation; ADMIN_OVERRIDE_EN adds admin count writes
module parking_floor_allocator
  import parking_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_CAP = 5,
  parameter int CAP_W = 4,
  parameter int SPECIAL_FLOOR = 0,
  parameter int RESERVED = 2,
  parameter int TICK_DIV = 10,
  parameter int GRANT_TICKS = 3,
  parameter int WRONG_TICKS = 5,
  localparam int FLR_W = flr_w(NUM_FLOORS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_exit,
  input  logic [FLR_W-1:0]            req_floor,
  input  logic                        req_special,
  input  logic                        req_id_ok,
`ifdef ADMIN_OVERRIDE_EN
  input  logic                        adm_wr,
  input  logic [FLR_W-1:0]            adm_floor,
  input  logic [CAP_W-1:0]            adm_count,
`endif
  output logic                        result_valid,
  output logic [2:0]                  result_code,
  output logic [FLR_W-1:0]            result_floor,
  output logic                        busy,
  output logic [NUM_FLOORS*CAP_W-1:0] free_cnt,
  output logic [CAP_W+FLR_W:0]        total_free
);
  localparam int TW = CAP_W + FLR_W + 1;
  localparam logic [CAP_W-1:0] CAP = CAP_W'(FLOOR_CAP);
  state_t state, state_n;
  logic [CAP_W-1:0] cnt [NUM_FLOORS];
  logic r_exit, r_special, r_id_ok, inc, dec, tick;
  logic [FLR_W-1:0] r_floor, idx, idx_n, tgt, floor_n;
  logic [2:0] code_n;
  logic [7:0] tick_cnt;
  logic [NUM_FLOORS-1:0] avail;
  logic [TW-1:0] sum;
`ifdef ADMIN_OVERRIDE_EN
  assign req_ready = state == IDLE && !adm_wr;
`else
  assign req_ready = state == IDLE;
`endif
  assign busy = state != IDLE;
  assign result_valid = state == HOLD;
  for (genvar g = 0; g < NUM_FLOORS; g++) assign free_cnt[g*CAP_W +: CAP_W] = cnt[g];
  parking_tick_gen #(.TICK_DIV(TICK_DIV), .CNT_W(8)) u_tick (
    .clk, .reset, .clr(state != HOLD), .tick, .ticks(tick_cnt)
  );
  // the special floor keeps its last RESERVED spaces for special IDs
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      avail[i] = (i == SPECIAL_FLOOR && !r_special) ? cnt[i] > CAP_W'(RESERVED) : cnt[i] != '0;
      sum = sum + TW'(cnt[i]);
    end
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    code_n = result_code;
    floor_n = result_floor;
    tgt = r_floor;
    inc = 1'b0;
    dec = 1'b0;
    case (state)
      IDLE: if (req_valid && req_ready) state_n = CHECK;
      CHECK: begin
        idx_n = '0;
        floor_n = r_floor;
        state_n = HOLD;
        if (!r_id_ok) code_n = RC_INVALID;
        else if (r_exit && cnt[r_floor] == CAP) code_n = RC_EXIT_ERR;
        else if (r_exit) begin
          code_n = RC_EXIT_OK;
          inc = 1'b1;
        end else if (avail[r_floor]) begin
          code_n = RC_GRANT_CHOSEN;
          dec = 1'b1;
        end else state_n = SEARCH;
      end
      SEARCH: begin
        tgt = idx;
        idx_n = idx + 1'b1;
        if (idx != r_floor && avail[idx]) begin
          state_n = HOLD;
          code_n = RC_GRANT_ALT;
          floor_n = idx;
          dec = 1'b1;
        end else if (idx == FLR_W'(NUM_FLOORS - 1)) begin
          state_n = HOLD;
          code_n = RC_NO_SPACE;
        end
      end
      HOLD: if (tick && tick_cnt == 8'(result_code == RC_INVALID ? WRONG_TICKS - 1 : GRANT_TICKS - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      result_code <= RC_NONE;
      result_floor <= '0;
      total_free <= TW'(NUM_FLOORS * FLOOR_CAP);
      {r_exit, r_special, r_id_ok, r_floor} <= '0;
      for (int i = 0; i < NUM_FLOORS; i++) cnt[i] <= CAP;
    end else begin
      idx <= idx_n;
      result_code <= code_n;
      result_floor <= floor_n;
      total_free <= sum;
      if (req_valid && req_ready) {r_exit, r_special, r_id_ok, r_floor} <= {req_exit, req_special, req_id_ok, req_floor};
      if (inc) cnt[tgt] <= cnt[tgt] + 1'b1;
      if (dec) cnt[tgt] <= cnt[tgt] - 1'b1;
`ifdef ADMIN_OVERRIDE_EN
      if (adm_wr && state == IDLE) cnt[adm_floor] <= adm_count > CAP ? CAP : adm_count;
`endif
    end
  end
endmodule
